// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, default oversampling and frame length.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'b00,
    TX_START = 2'b01,
    TX_DATA  = 2'b10,
    TX_STOP  = 2'b11
  } tx_state_t;

  localparam int TX_OVERSAMPLE = 16;
  // start + 8 data + stop
  localparam int TX_FRAME_BITS = 10;

  function automatic int tx_frame_cycles(input int os);
    return TX_FRAME_BITS * os;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with count-based full/empty; a simultaneous push and pop are both
// honoured even when full, so the count stays put.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push, w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: byte FIFO feeding a start/data/stop shifter, one bit per
// OVERSAMPLE clocks, with a registered serial output.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = TX_OVERSAMPLE,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_status,
  output logic                 tx_busy,
  output logic                 tx_overflow,
  output logic                 uart_tx
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

  tx_state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_overflow;
  logic                 w_pop, w_full, w_empty, w_bit_end;
  logic [DATA_BITS-1:0] w_dout;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_en),
    .pop   (w_pop),
    .din   (tx_data),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_bit_end   = (r_bit_cnt == CNT_MAX);
  assign tx_status   = !w_full;
  assign tx_busy     = (r_state != TX_IDLE) || !w_empty;
  assign tx_overflow = r_overflow;
  assign uart_tx     = r_tx;

  // The line level is computed for the state being entered, so uart_tx changes on that edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_pop         = 1'b0;
    case (r_state)
      TX_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_dout;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = TX_START;
          w_tx_nxt      = 1'b0;
        end
      end
      TX_START: begin
        if (w_bit_end) begin
          w_bit_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = TX_DATA;
          w_tx_nxt      = r_shift[0];
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (w_bit_end) begin
          w_bit_cnt_nxt = '0;
          w_shift_nxt   = r_shift >> 1;
          if (r_bit_idx == IDX_MAX) begin
            w_state_nxt = TX_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
            w_tx_nxt      = w_shift_nxt[0];
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (w_bit_end) begin
          w_bit_cnt_nxt = '0;
          // Chain straight into the next frame when more data is queued.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_dout;
            w_state_nxt = TX_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = TX_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= TX_IDLE;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      // A same-cycle pop frees a slot, so only an unserved write while full is dropped.
      r_overflow <= tx_en && w_full && !w_pop;
    end
  end

endmodule
